// File: rtl/fluorescence_frame_tx.sv
// UART transmitter for photon-count measurements: one 10-byte frame
// (sync, add count, subtract count, XOR checksum) per accepted measurement, 8N1.
module fluorescence_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [31:0] add_count_in,
    input  logic [31:0] subtract_count_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        tx_out,
    output logic        busy
);

    localparam int unsigned TIMER_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned LAST_BYTE = 9;
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_cnt;
    logic [3:0]         byte_idx;
    logic [7:0]         shift;
    logic [31:0]        add_q;
    logic [31:0]        sub_q;
    logic [7:0]         csum_q;

    logic [7:0] in_csum_c;
    logic [3:0] next_idx_c;
    logic [7:0] next_byte_c;

    // Checksum over the eight count bytes as presented on the accept edge
    always_comb begin
        in_csum_c = add_count_in[7:0]   ^ add_count_in[15:8]
                  ^ add_count_in[23:16] ^ add_count_in[31:24]
                  ^ subtract_count_in[7:0]   ^ subtract_count_in[15:8]
                  ^ subtract_count_in[23:16] ^ subtract_count_in[31:24];
    end

    // Byte to load after the current byte's stop bit (byte 0 is loaded on accept)
    always_comb begin
        next_idx_c  = byte_idx + 4'd1;
        next_byte_c = csum_q;
        case (next_idx_c)
            4'd1:    next_byte_c = add_q[7:0];
            4'd2:    next_byte_c = add_q[15:8];
            4'd3:    next_byte_c = add_q[23:16];
            4'd4:    next_byte_c = add_q[31:24];
            4'd5:    next_byte_c = sub_q[7:0];
            4'd6:    next_byte_c = sub_q[15:8];
            4'd7:    next_byte_c = sub_q[23:16];
            4'd8:    next_byte_c = sub_q[31:24];
            default: next_byte_c = csum_q;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            shift       <= '0;
            add_q       <= '0;
            sub_q       <= '0;
            csum_q      <= '0;
            tx_out      <= 1'b1;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        add_q       <= add_count_in;
                        sub_q       <= subtract_count_in;
                        csum_q      <= in_csum_c;
                        byte_idx    <= '0;
                        shift       <= SYNC_BYTE;
                        timer       <= BIT_LAST;
                        tx_out      <= 1'b0;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        timer   <= BIT_LAST;
                        bit_cnt <= '0;
                        tx_out  <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= BIT_LAST;
                        if (bit_cnt == 3'd7) begin
                            tx_out <= 1'b1;
                            state  <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx_out  <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        if (byte_idx == 4'(LAST_BYTE)) begin
                            frame_ready <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            byte_idx <= next_idx_c;
                            shift    <= next_byte_c;
                            timer    <= BIT_LAST;
                            tx_out   <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fluorescence_frame_tx.sv
// Bench for fluorescence_frame_tx: samples tx_out every cycle and compares decoded
// bytes and exact bit timing against a frame model built from the framing rules.
module tb_fluorescence_frame_tx;

    localparam int C     = 4;
    localparam int FBITS = 100;

    logic        clock_in = 1'b0;
    logic        reset;
    logic [31:0] add_count_in;
    logic [31:0] subtract_count_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        tx_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic tx_s  [0:999];
    logic rdy_s [0:999];
    logic bsy_s [0:999];

    fluorescence_frame_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
        .clock_in          (clock_in),
        .reset             (reset),
        .add_count_in      (add_count_in),
        .subtract_count_in (subtract_count_in),
        .frame_valid       (frame_valid),
        .frame_ready       (frame_ready),
        .tx_out            (tx_out),
        .busy              (busy)
    );

    always #5 clock_in = ~clock_in;

    // Frame byte i: sync, add LSB-first, subtract LSB-first, XOR of all eight count bytes
    function automatic logic [7:0] model_byte(input int i, input logic [31:0] a, input logic [31:0] s);
        logic [7:0] cs;
        cs = 8'h00;
        for (int n = 0; n < 4; n++) cs = cs ^ 8'(a >> (8 * n)) ^ 8'(s >> (8 * n));
        if (i == 0) return 8'hA5;
        if (i <= 4) return 8'(a >> (8 * (i - 1)));
        if (i <= 8) return 8'(s >> (8 * (i - 5)));
        return cs;
    endfunction

    function automatic logic model_bit(input int k, input logic [31:0] a, input logic [31:0] s);
        int p;
        logic [7:0] v;
        p = k % 10;
        v = model_byte(k / 10, a, s);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return v[p - 1];
    endfunction

    // Mid-bit sampling of data bits of byte b in a frame whose start bit is sample off
    function automatic logic [7:0] decode_byte(input int off, input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = tx_s[off + (b * 10 + 1 + i) * C + C / 2];
        return v;
    endfunction

    function automatic int bit_errors(input int off, input logic [31:0] a, input logic [31:0] s);
        int e;
        e = 0;
        for (int j = 0; j < FBITS * C; j++)
            if (tx_s[off + j] !== model_bit(j / C, a, s)) e++;
        return e;
    endfunction

    // Present a measurement and return just after the edge that accepts it
    task automatic start_frame(input logic [31:0] a, input logic [31:0] s);
        int n;
        @(negedge clock_in);
        add_count_in      = a;
        subtract_count_in = s;
        frame_valid       = 1'b1;
        n = 0;
        while (frame_ready !== 1'b1 && n < 2000) begin
            @(negedge clock_in);
            n++;
        end
        checks++;
        if (frame_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait: frame_ready=%b after %0d cycles, required 1", frame_ready, n);
        end
        @(posedge clock_in);
    endtask

    // Sample n negedges after the accept edge; drive input events at samples ev1 and ev2
    task automatic capture(input int n, input int ev1, input logic v1,
                           input logic [31:0] na, input logic [31:0] ns, input int ev2);
        for (int j = 0; j < n; j++) begin
            @(negedge clock_in);
            if (j == ev1) begin
                add_count_in      = na;
                subtract_count_in = ns;
                frame_valid       = v1;
            end
            if (j == ev2) frame_valid = 1'b0;
            tx_s[j]  = tx_out;
            rdy_s[j] = frame_ready;
            bsy_s[j] = busy;
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        frame_valid = 1'b0;
        add_count_in = '0;
        subtract_count_in = '0;
        repeat (3) @(negedge clock_in);
        checks++;
        if (tx_out !== 1'b1 || frame_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: tx=%b ready=%b busy=%b, required 1 1 0", tx_out, frame_ready, busy);
        end
        reset = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clock_in);
            if (tx_out !== 1'b1 || frame_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_after_reset: %0d cycles deviated, required 0", bad);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] a = 32'h0000_0001, s = 32'h0000_0002;
        int low, e;
        start_frame(a, s);
        capture(FBITS * C + 1, 0, 1'b0, $urandom, $urandom, -1);
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (decode_byte(0, b) !== model_byte(b, a, s)) begin
                failures++;
                $display("FAIL single_byte%0d: got %h, required %h", b, decode_byte(0, b), model_byte(b, a, s));
            end
        end
        e = bit_errors(0, a, s);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL single_bit_timing: %0d wrong samples, required 0", e);
        end
        low = 0;
        for (int j = 0; j < FBITS * C; j++) if (rdy_s[j] === 1'b0 && bsy_s[j] === 1'b1) low++;
        checks++;
        if (low != FBITS * C || rdy_s[FBITS * C] !== 1'b1 || bsy_s[FBITS * C] !== 1'b0 || tx_s[FBITS * C] !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_window: busy cycles=%0d end ready=%b busy=%b tx=%b, required 400 1 0 1",
                     low, rdy_s[FBITS * C], bsy_s[FBITS * C], tx_s[FBITS * C]);
        end
    endtask

    // Checksum is the XOR of all eight count bytes (08 ^ 22 = 2A for these counts)
    task automatic test_checksum_order();
        logic [31:0] a = 32'h1234_5678, s = 32'hDEAD_BEEF;
        start_frame(a, s);
        capture(FBITS * C + 1, 0, 1'b0, '0, '0, -1);
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (decode_byte(0, b) !== model_byte(b, a, s)) begin
                failures++;
                $display("FAIL order_byte%0d: got %h, required %h", b, decode_byte(0, b), model_byte(b, a, s));
            end
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] a, s;
        int e;
        for (int f = 0; f < 4; f++) begin
            a = $urandom;
            s = $urandom;
            start_frame(a, s);
            capture(FBITS * C + 1, 0, 1'b0, $urandom, $urandom, -1);
            for (int b = 0; b < 10; b++) begin
                checks++;
                if (decode_byte(0, b) !== model_byte(b, a, s)) begin
                    failures++;
                    $display("FAIL random%0d_byte%0d: got %h, required %h", f, b, decode_byte(0, b), model_byte(b, a, s));
                end
            end
            e = bit_errors(0, a, s);
            checks++;
            if (e != 0) begin
                failures++;
                $display("FAIL random%0d_bit_timing: %0d wrong samples, required 0", f, e);
            end
            repeat ($urandom_range(0, 5)) @(negedge clock_in);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = $urandom, s1 = $urandom, a2 = $urandom, s2 = $urandom;
        int off, e1, e2;
        off = FBITS * C + 1;
        start_frame(a1, s1);
        capture(2 * off, 0, 1'b1, a2, s2, off);
        checks++;
        if (tx_s[off - 1] !== 1'b1 || tx_s[off] !== 1'b0 || rdy_s[off - 1] !== 1'b1 || rdy_s[off] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: tx[400]=%b tx[401]=%b ready[400]=%b ready[401]=%b, required 1 0 1 0",
                     tx_s[off - 1], tx_s[off], rdy_s[off - 1], rdy_s[off]);
        end
        e1 = bit_errors(0, a1, s1);
        e2 = bit_errors(off, a2, s2);
        checks++;
        if (e1 != 0) begin
            failures++;
            $display("FAIL b2b_first_frame: %0d wrong samples, required 0", e1);
        end
        checks++;
        if (e2 != 0) begin
            failures++;
            $display("FAIL b2b_second_frame: %0d wrong samples, required 0", e2);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a = $urandom, s = $urandom;
        int e, extra;
        start_frame(a, s);
        capture(500, 0, 1'b0, '0, '0, -1);
        e = bit_errors(0, a, s);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL backpressure_idle_frame: %0d wrong samples, required 0", e);
        end
        start_frame(a, s);
        capture(500, 150, 1'b1, ~a, ~s, 152);
        e = bit_errors(0, a, s);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL backpressure_frame: %0d wrong samples, required 0", e);
        end
        extra = 0;
        for (int j = FBITS * C; j < 500; j++) if (tx_s[j] !== 1'b1 || rdy_s[j] !== 1'b1) extra++;
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL backpressure_no_second: %0d non-idle cycles after frame, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] a = $urandom, s = $urandom;
        int e;
        start_frame(a, s);
        @(negedge clock_in);
        frame_valid = 1'b0;
        repeat (129) @(negedge clock_in);
        checks++;
        if (frame_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_busy_before: ready=%b, required 0", frame_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1 || frame_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: tx=%b ready=%b busy=%b, required 1 1 0", tx_out, frame_ready, busy);
        end
        repeat (3) @(negedge clock_in);
        reset = 1'b1;
        a = $urandom;
        s = $urandom;
        start_frame(a, s);
        capture(FBITS * C + 1, 0, 1'b0, '0, '0, -1);
        checks++;
        if (decode_byte(0, 0) !== 8'hA5) begin
            failures++;
            $display("FAIL midreset_sync: got %h, required a5", decode_byte(0, 0));
        end
        e = bit_errors(0, a, s);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL midreset_next_frame: %0d wrong samples, required 0", e);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_checksum_order();
        test_random_frames();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
